// File: rtl/arb_mux_pkg.sv
// Shared constants for the arb_mux_n source multiplexer: mode encodings and
// default geometry.
package arb_mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   DEF_N      = 32;
   localparam int   DEF_SRCS   = 4;
endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Rotating-priority search: first set bit of req at or after ptr, wrapping
// from SRCS-1 back to 0. Purely combinational.
module rr_pick #(
   parameter int SRCS  = 4,
   parameter int SEL_W = $clog2(SRCS)
) (
   input  logic [SRCS-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_id
);

   int idx;

   // Walk from the farthest candidate back towards ptr so the closest hit wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      for (int k = SRCS - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= SRCS) begin
            idx = idx - SRCS;
         end
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/arb_mux_n.sv
// N-source registered multiplexer with fixed-select or round-robin arbitration.
// Define ARB_MUX_LOCK_EN to hold a grant on one source until its src_last beat.
module arb_mux_n
   import arb_mux_pkg::*;
#(
   parameter  int N     = DEF_N,
   parameter  int SRCS  = DEF_SRCS,
   localparam int SEL_W = $clog2(SRCS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SRCS*N-1:0]   src_data,
   input  logic [SRCS-1:0]     src_valid,
   output logic [SRCS-1:0]     src_ready,
   input  logic [SRCS-1:0]     src_last,
   input  logic                mode,
   input  logic [SEL_W-1:0]    sel,
   output logic [N-1:0]        z,
   output logic                z_valid,
   input  logic                z_ready,
   output logic [SEL_W-1:0]    grant_id
);

   logic [N-1:0]     src_word [SRCS];
   logic [N-1:0]     z_reg;
   logic             z_valid_reg;
   logic [SEL_W-1:0] grant_reg;
   logic [SEL_W-1:0] ptr_reg;
   logic [SEL_W-1:0] ptr_next;

   logic             load;
   logic             accept;
   logic [SRCS-1:0]  sel_hot;
   logic             fix_valid;
   logic             rr_valid;
   logic [SEL_W-1:0] rr_id;
   logic             win_valid;
   logic [SEL_W-1:0] win_id;

`ifdef ARB_MUX_LOCK_EN
   logic             lock_reg;
   logic [SEL_W-1:0] locked_id_reg;
`else
   logic             unused_last;
   assign unused_last = ^src_last;
`endif

   for (genvar gi = 0; gi < SRCS; gi++) begin : g_unpack
      assign src_word[gi]  = src_data[gi*N +: N];
      assign src_ready[gi] = rst_n && accept && (win_id == SEL_W'(gi));
   end

   assign load = !z_valid_reg || z_ready;

   // A sel beyond the last source shifts the bit out, leaving nothing eligible.
   assign sel_hot   = SRCS'(1) << sel;
   assign fix_valid = |(src_valid & sel_hot);

   rr_pick #(
      .SRCS  (SRCS),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req       (src_valid),
      .ptr       (ptr_reg),
      .gnt_valid (rr_valid),
      .gnt_id    (rr_id)
   );

   always_comb begin
      win_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
      win_id    = (mode == MODE_RR) ? rr_id    : sel;
`ifdef ARB_MUX_LOCK_EN
      if (lock_reg) begin
         win_valid = src_valid[locked_id_reg];
         win_id    = locked_id_reg;
      end
`endif
   end

   assign accept = load && win_valid;

   always_comb begin
      ptr_next = ptr_reg;
      if (accept && (mode == MODE_RR)) begin
         ptr_next = (win_id == SEL_W'(SRCS - 1)) ? '0 : win_id + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_reg       <= '0;
         z_valid_reg <= 1'b0;
         grant_reg   <= '0;
         ptr_reg     <= '0;
      end else begin
         ptr_reg <= ptr_next;
         if (load) begin
            if (win_valid) begin
               z_reg       <= src_word[win_id];
               z_valid_reg <= 1'b1;
               grant_reg   <= win_id;
            end else begin
               z_valid_reg <= 1'b0;
            end
         end
      end
   end

`ifdef ARB_MUX_LOCK_EN
   // The lock follows whichever source just delivered a non-final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_reg      <= 1'b0;
         locked_id_reg <= '0;
      end else if (accept) begin
         lock_reg      <= !src_last[win_id];
         locked_id_reg <= win_id;
      end
   end
`endif

   assign z        = z_reg;
   assign z_valid  = z_valid_reg;
   assign grant_id = grant_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed self-checking bench for arb_mux_n (N=32, SRCS=4) with a beat
// scoreboard; the lock sequence runs only when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux_n;

   localparam int N    = 32;
   localparam int SRCS = 4;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  id;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [SRCS*N-1:0] src_data;
   logic [SRCS-1:0]   src_valid;
   logic [SRCS-1:0]   src_ready;
   logic [SRCS-1:0]   src_last;
   logic              mode;
   logic [1:0]        sel;
   logic [N-1:0]      z;
   logic              z_valid;
   logic              z_ready;
   logic [1:0]        grant_id;

   logic [31:0] w [4];
   beat_t       sb [$];
   int          tests = 0;
   int          fails = 0;

   arb_mux_n #(.N(N), .SRCS(SRCS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_last  (src_last),
      .mode      (mode),
      .sel       (sel),
      .z         (z),
      .z_valid   (z_valid),
      .z_ready   (z_ready),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs are already driven; check the accept strobe, then the registered beat.
   task automatic step(input logic [3:0] exp_rdy, input bit beat,
                       input logic [31:0] d, input logic [1:0] id);
      beat_t b;
      #1;
      check("src_ready", 32'(src_ready), 32'(exp_rdy));
      if (beat) begin
         b.d  = d;
         b.id = id;
         sb.push_back(b);
      end
      @(posedge clk);
      #1;
      if (beat) begin
         b = sb.pop_front();
         check("z", z, b.d);
         check("grant_id", 32'(grant_id), 32'(b.id));
         check("z_valid", 32'(z_valid), 32'd1);
         $display("[TB] beat z=%h grant_id=%0d", z, grant_id);
      end else begin
         check("z_valid_idle", 32'(z_valid), 32'd0);
         $display("[TB] idle cycle z_valid=%0d", z_valid);
      end
   endtask

   initial begin
      w[0] = 32'h1234;
      w[1] = 32'h4567;
      w[2] = 32'h98785;
      w[3] = 32'h1111;
      src_data  = {w[3], w[2], w[1], w[0]};
      rst_n     = 1'b0;
      src_valid = 4'hF;
      src_last  = 4'hF;
      mode      = 1'b0;
      sel       = 2'd0;
      z_ready   = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_z", z, 32'd0);
      check("rst_z_valid", 32'(z_valid), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_src_ready", 32'(src_ready), 32'd0);
      rst_n = 1'b1;

      // Fixed select walking sel 0..3
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         step(4'(1 << s), 1'b1, w[s], 2'(s));
      end

      // Round-robin with all sources valid, wrapping back to 0
      mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(4'(1 << (k % 4)), 1'b1, w[k % 4], 2'(k % 4));
      end

      // Back-pressure: beat from src1 held for three cycles
      step(4'b0010, 1'b1, w[1], 2'd1);
      z_ready = 1'b0;
      for (int h = 0; h < 3; h++) begin
         #1;
         check("hold_src_ready", 32'(src_ready), 32'd0);
         @(posedge clk);
         #1;
         check("hold_z", z, w[1]);
         check("hold_grant_id", 32'(grant_id), 32'd1);
         check("hold_z_valid", 32'(z_valid), 32'd1);
         $display("[TB] held z=%h grant_id=%0d", z, grant_id);
      end
      z_ready = 1'b1;
      step(4'b0100, 1'b1, w[2], 2'd2);

      // ptr=3 with only src2 valid wraps the search; ptr lands back on 3
      src_valid = 4'b0100;
      step(4'b0100, 1'b1, w[2], 2'd2);
      src_valid = 4'hF;
      step(4'b1000, 1'b1, w[3], 2'd3);

      // No valid source: z_valid drops, z and grant_id hold
      src_valid = 4'h0;
      step(4'b0000, 1'b0, 32'd0, 2'd0);
      check("empty_z_hold", z, w[3]);
      check("empty_grant_hold", 32'(grant_id), 32'd3);

      // Fixed select on an invalid source grants nothing
      mode      = 1'b0;
      sel       = 2'd1;
      src_valid = 4'b1101;
      step(4'b0000, 1'b0, 32'd0, 2'd0);

      // ptr untouched by idle and fixed cycles
      mode      = 1'b1;
      sel       = 2'd0;
      src_valid = 4'hF;
      step(4'b0001, 1'b1, w[0], 2'd0);
      step(4'b0010, 1'b1, w[1], 2'd1);

      // Asynchronous reset with a beat held
      rst_n = 1'b0;
      #1;
      check("async_rst_z", z, 32'd0);
      check("async_rst_z_valid", 32'(z_valid), 32'd0);
      check("async_rst_grant_id", 32'(grant_id), 32'd0);
      check("async_rst_src_ready", 32'(src_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'b0001, 1'b1, w[0], 2'd0);

`ifdef ARB_MUX_LOCK_EN
      // src1 packet of three beats keeps the grant despite src0/src2 waiting
      src_valid = 4'b0111;
      src_last  = 4'b1101;
      step(4'b0010, 1'b1, w[1], 2'd1);
      step(4'b0010, 1'b1, w[1], 2'd1);
      src_last  = 4'b1111;
      step(4'b0010, 1'b1, w[1], 2'd1);
      step(4'b0100, 1'b1, w[2], 2'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter N, default 32, data width per source.
REQ-002 SHALL have parameter SRCS, default 4, source count (2..16); SEL_W = clog2(SRCS).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port src_data  input  SRCS*N  packed sources, source i at bits [i*N +: N].
REQ-006 SHALL have port src_valid  input  SRCS  per-source valid.
REQ-007 SHALL have port src_ready  output  SRCS  per-source accept strobe, one-hot or zero.
REQ-008 SHALL have port src_last  input  SRCS  per-source end-of-packet flag (used only with ARB_MUX_LOCK_EN).
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SEL_W  source index in fixed mode.
REQ-011 SHALL have port z  output  N  registered selected data.
REQ-012 SHALL have port z_valid  output  1  z holds an unconsumed beat.
REQ-013 SHALL have port z_ready  input  1  downstream accepts z this cycle.
REQ-014 SHALL have port grant_id  output  SEL_W  source index of beat in z.

Function
REQ-015 SHALL load the output register when load = !z_valid || z_ready.
REQ-016 SHALL, on load with an eligible valid source, register its data into z, set z_valid=1, grant_id=winner, and assert src_ready[winner] combinationally in that cycle.
REQ-017 SHALL, on load with no eligible valid source, clear z_valid and hold z and grant_id.
REQ-018 SHALL keep src_ready all-zero while !load; z, z_valid, grant_id stable while z_valid && !z_ready.
REQ-019 SHALL, mode=0, treat only source sel as eligible; sel >= SRCS yields no eligible source.
REQ-020 SHALL, mode=1, grant the first valid source at or after rotation pointer ptr (wrapping SRCS-1 -> 0), then set ptr = winner+1 mod SRCS on each accepted beat.
REQ-021 SHALL leave ptr unchanged when no beat is accepted or mode=0.
REQ-022 SHALL achieve one beat per cycle with z_ready held high; latency source accept -> z_valid one cycle.
REQ-023 SHALL sample mode and sel each cycle; a change takes effect on the next load, never disturbing a held beat.

Reset
REQ-024 SHALL, while rst_n=0, force z=0, z_valid=0, grant_id=0, ptr=0, lock cleared, src_ready=0.
REQ-025 SHALL, on reset mid-transfer, discard the held beat; first post-reset grant follows REQ-019/020 from ptr=0.

Configuration
REQ-026 SHALL, with ARB_MUX_LOCK_EN defined, set lock and locked_id=winner on accepting a beat with src_last[winner]=0, restricting eligibility to locked_id (ignoring mode, sel) until a beat with src_last=1 from it is accepted.
REQ-027 SHALL, without ARB_MUX_LOCK_EN, omit lock state, ignore src_last, and arbitrate every beat independently.

Structure
REQ-028 SHALL take MODE_FIXED=1'b0, MODE_RR=1'b1 and default N/SRCS constants from shared package arb_mux_pkg.
REQ-029 SHALL implement the rotating-priority search as combinational sub-module rr_pick (inputs req, ptr; outputs gnt_valid, gnt_id).

Verification
REQ-030 SHALL check: N=32, SRCS=4, mode=0, src0..3=32'h1234/32'h4567/32'h98785/32'h1111 all valid, z_ready=1, sel 0..3 one per cycle -> z follows one cycle later, grant_id 0..3.
REQ-031 SHALL check: mode=1, all four valid continuously, z_ready=1 -> grant_id 0,1,2,3,0 on consecutive cycles, wrap observed.
REQ-032 SHALL check: z_valid=1 with z=32'h4567, z_ready=0 for 3 cycles -> z, grant_id stable, src_ready=0; z_ready=1 -> next beat loads in same cycle.
REQ-033 SHALL check: mode=1, only src2 valid, ptr=3 -> grant 2 (wrap search), ptr becomes 3.
REQ-034 SHALL check: rst_n low mid-stream with z_valid=1 -> z=0, z_valid=0, grant_id=0 immediately; after release, mode=1 grants src0 first.
REQ-035 SHALL check, ARB_MUX_LOCK_EN: src1 sends 3 beats last=0,0,1 while src0,src2 valid -> three consecutive grant_id=1, then round-robin resumes at src2.
